// File: rtl/hex_display_bank.sv
// hex_display_bank: seven-segment display engine for a bank of HEX digits.
// Hex loads take effect immediately. Decimal loads go through a double-dabble
// converter that handles one input bit per cycle, followed by a latch cycle.
module hex_display_bank #(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  dec_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_segs
);

  localparam int NB = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [NB-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic                blank_q, blank_d;
  logic [7*DIGITS-1:0] segs_q, segs_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic [NB-1:0]       hex_nib;
  logic                hex_ovf;
  logic [NB-1:0]       bcd_adj;

  // Active-low gfedcba glyph for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Builds the whole bank. Overflow turns every digit into a dash. Otherwise,
  // with blanking on, digits above the first nonzero one are dark, but digit 0
  // always lights.
  function automatic logic [7*DIGITS-1:0] render(input logic [NB-1:0] nib,
                                                 input logic          ovf,
                                                 input logic          blank);
    logic [7*DIGITS-1:0] r;
    logic                seen;
    logic [3:0]          d;
    r    = '1;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = nib[4*i +: 4];
      if (d != 4'd0) seen = 1'b1;
      if (ovf)                               r[7*i +: 7] = 7'b0111111;
      else if (blank && !seen && (i != 0))   r[7*i +: 7] = 7'b1111111;
      else                                   r[7*i +: 7] = seg7(d);
    end
    return r;
  endfunction

  // Zero-extend or truncate value into one nibble per digit for hex display.
  for (genvar gi = 0; gi < NB; gi++) begin : g_ext
    if (gi < WIDTH) begin : g_bit
      assign hex_nib[gi] = value[gi];
    end else begin : g_zero
      assign hex_nib[gi] = 1'b0;
    end
  end

  // Hex overflow means the value has set bits that no digit can show.
  if (WIDTH > NB) begin : g_hex_ovf
    assign hex_ovf = |value[WIDTH-1:NB];
  end else begin : g_no_hex_ovf
    assign hex_ovf = 1'b0;
  end

  // Double-dabble correction: add 3 to each BCD nibble of 5 or more before shifting.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                            : bcd_q[4*gi +: 4];
  end

  // State and datapath registers. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      blank_q    <= 1'b0;
      segs_q     <= '1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      blank_q    <= blank_d;
      segs_q     <= segs_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: hex loads in IDLE, one conversion bit per SHIFT cycle, publish in LATCH.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    blank_d    = blank_q;
    segs_d     = segs_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (dec_mode) begin
            shift_d    = value;
            bcd_d      = '0;
            ovf_flag_d = 1'b0;
            blank_d    = blank_lz;
            cnt_d      = CW'(WIDTH);
            state_d    = SHIFT;
          end else begin
            segs_d     = render(hex_nib, hex_ovf, blank_lz);
            overflow_d = hex_ovf;
            done_d     = 1'b1;
          end
        end
      end
      SHIFT: begin
        bcd_d   = {bcd_adj[NB-2:0], shift_q[WIDTH-1]};
        shift_d = shift_q << 1;
        // A carry out of the top digit means the value needs more digits than the bank has.
        if (bcd_adj[NB-1]) ovf_flag_d = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = LATCH;
      end
      LATCH: begin
        segs_d     = render(bcd_q, ovf_flag_q, blank_q);
        overflow_d = ovf_flag_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign hex_segs = segs_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank. An 8-digit and a 4-digit instance
// share all inputs, and each vector has expected values written out by hand.
module tb_hex_display_bank;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] value = '0;
  logic        load = 1'b0;
  logic        dec_mode = 1'b0;
  logic        blank_lz = 1'b0;

  logic        busy8, done8, ovf8;
  logic [55:0] segs8;
  logic        busy4, done4, ovf4;
  logic [27:0] segs4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hex_display_bank #(.DIGITS(8), .WIDTH(18)) dut8 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .busy(busy8), .done(done8), .overflow(ovf8), .hex_segs(segs8)
  );

  hex_display_bank #(.DIGITS(4), .WIDTH(18)) dut4 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .busy(busy4), .done(done4), .overflow(ovf4), .hex_segs(segs4)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one load at a negedge, let edge E0 take it, then return #1 after E0.
  task automatic start(input logic [17:0] v, input logic dm, input logic bl);
    @(negedge clk);
    value = v; dec_mode = dm; blank_lz = bl; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    $display("load value=%0d dec=%0b blank=%0b", v, dm, bl);
  endtask

  // Count edges until done rises, with a bound. Called just after E0.
  task automatic wait_done(output int n);
    n = 0;
    while (!done8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;
  int dcount;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_segs8", 64'(segs8), 64'({8{BL}}));
    check_vec("rst_segs4", 64'(segs4), 64'({4{BL}}));
    check_vec("rst_flags", 64'({busy8, done8, ovf8}), 64'(3'b000));
    @(negedge clk);
    rst = 1'b0;

    // Hex, no blanking
    start(18'h0000F, 1'b0, 1'b0);
    check_vec("hexF_segs8", 64'(segs8), 64'({{7{S0}}, SF}));
    check_vec("hexF_segs4", 64'(segs4), 64'({{3{S0}}, SF}));
    check_vec("hexF_ovf", 64'({ovf8, ovf4}), 64'(2'b00));
    check_vec("hexF_done_hi", 64'({done8, busy8}), 64'(2'b10));
    @(posedge clk); #1;
    check_vec("hexF_done_lo", 64'(done8), 64'(1'b0));

    // Decimal 15 with blanking; busy lasts WIDTH+1 = 19 cycles
    start(18'd15, 1'b1, 1'b1);
    n = 0;
    while (busy8 && n < 100) begin
      check_vec("dec15_no_done_while_busy", 64'(done8), 64'(1'b0));
      n++;
      @(posedge clk); #1;
    end
    check_vec("dec15_busy_cycles", 64'(n), 64'(19));
    check_vec("dec15_done_hi", 64'(done8), 64'(1'b1));
    check_vec("dec15_segs8", 64'(segs8), 64'({{6{BL}}, S1, S5}));
    check_vec("dec15_segs4", 64'(segs4), 64'({BL, BL, S1, S5}));
    @(posedge clk); #1;
    check_vec("dec15_done_lo", 64'(done8), 64'(1'b0));

    // Decimal maximum
    start(18'd262143, 1'b1, 1'b1);
    wait_done(n);
    check_vec("max_latency", 64'(n), 64'(19));
    check_vec("max_segs8", 64'(segs8), 64'({BL, BL, S2, S6, S2, S1, S4, S3}));
    check_vec("max_ovf8", 64'(ovf8), 64'(1'b0));
    check_vec("max_segs4", 64'(segs4), 64'({4{DS}}));
    check_vec("max_ovf4", 64'(ovf4), 64'(1'b1));

    // Decimal overflow on the 4-digit bank
    @(posedge clk); #1;
    start(18'd12345, 1'b1, 1'b0);
    wait_done(n);
    check_vec("d12345_segs4", 64'(segs4), 64'({4{DS}}));
    check_vec("d12345_ovf4", 64'(ovf4), 64'(1'b1));
    check_vec("d12345_segs8", 64'(segs8), 64'({S0, S0, S0, S1, S2, S3, S4, S5}));
    check_vec("d12345_ovf8", 64'(ovf8), 64'(1'b0));

    // Hex overflow on the 4-digit bank
    @(posedge clk); #1;
    start(18'h10000, 1'b0, 1'b0);
    check_vec("h10000_segs4", 64'(segs4), 64'({4{DS}}));
    check_vec("h10000_ovf4", 64'(ovf4), 64'(1'b1));
    check_vec("h10000_segs8", 64'(segs8), 64'({S0, S0, S0, S1, S0, S0, S0, S0}));
    check_vec("h10000_done", 64'({done8, ovf8}), 64'(2'b10));

    // A load while busy is ignored
    @(posedge clk); #1;
    start(18'd15, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    start(18'd7, 1'b1, 1'b1);
    check_vec("busy_load_busy", 64'(busy8), 64'(1'b1));
    wait_done(n);
    check_vec("busy_load_latency", 64'(n), 64'(14));
    check_vec("busy_load_segs8", 64'(segs8), 64'({{6{BL}}, S1, S5}));

    // Reset mid-conversion
    @(posedge clk); #1;
    start(18'd99, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_vec("midrst_segs8", 64'(segs8), 64'({8{BL}}));
    check_vec("midrst_flags", 64'({busy8, done8, ovf8}), 64'(3'b000));
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcount++;
    end
    check_vec("midrst_no_done", 64'(dcount), 64'(0));
    check_vec("midrst_segs_hold", 64'(segs8), 64'({8{BL}}));

    // Zero with blanking, both modes
    start(18'd0, 1'b0, 1'b1);
    check_vec("zero_hex_segs8", 64'(segs8), 64'({{7{BL}}, S0}));
    check_vec("zero_hex_segs4", 64'(segs4), 64'({BL, BL, BL, S0}));
    @(posedge clk); #1;
    start(18'd0, 1'b1, 1'b1);
    wait_done(n);
    check_vec("zero_dec_segs8", 64'(segs8), 64'({{7{BL}}, S0}));
    check_vec("zero_dec_ovf", 64'({ovf8, ovf4}), 64'(2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
